systolic_feeder: RTL and testbench

- Upstream operand sequencer for the N×N systolicarray.
- Accepts one A (N×N int8) and one B (N×N int8) operand pair through a ready/start handshake and latches both.
- Emits skewed per-row A streams and per-column B streams on the array's boundary inputs (index 0 of each row/column lane).
- Generates the array's process enable and accumulator-clear, then flags completion once the last product has reached PE(N-1,N-1).

---
 rtl/systolic_feeder_if.sv | 30 +++
 rtl/systolic_feeder.sv | 122 ++++++++++++
 tb/tb_systolic_feeder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_feeder_if: operand handshake and array-boundary bus      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface systolic_feeder_if #(
   parameter int N = 16
);
   logic               start;
   logic               ready;
   logic [N*N*8-1:0]   a_mat;
   logic [N*N*8-1:0]   b_mat;
   logic [N*8-1:0]     row_data;
   logic [N*8-1:0]     col_data;
   logic               process;
   logic               acc_clr;
   logic               busy;
   logic               done;

   modport master (
      output start, a_mat, b_mat,
      input  ready, row_data, col_data, process, acc_clr, busy, done
   );

   modport slave (
      input  start, a_mat, b_mat,
      output ready, row_data, col_data, process, acc_clr, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_feeder: latches an A/B operand pair and streams it skewed |
// | into an NxN systolic array, then flags completion.  Rev 1.0        |
// +------------------------------------------------------------------+
module systolic_feeder #(
   parameter int N      = 16,
   parameter int PE_LAT = 1
) (
   input  wire logic        clk,
   input  wire logic        rst,
   systolic_feeder_if.slave bus
);
   localparam int CW        = $clog2(3*N + PE_LAT) + 1;
   localparam int DRAIN_LEN = N - 1 + PE_LAT;

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_CLEAR = 3'd1;
   localparam logic [2:0] c_ST_FEED  = 3'd2;
   localparam logic [2:0] c_ST_DRAIN = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;

   localparam bit          c_HAS_DRAIN  = (DRAIN_LEN > 0);
   localparam logic [CW-1:0] c_FEED_LAST  = CW'(2*N - 2);
   localparam logic [CW-1:0] c_DRAIN_LAST = CW'(c_HAS_DRAIN ? DRAIN_LEN - 1 : 0);

   logic [2:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [N*N*8-1:0]   r_a;
   logic [N*N*8-1:0]   r_b;
   logic [N*8-1:0]     r_row;
   logic [N*8-1:0]     r_col;
   logic               r_process;
   logic               r_acc_clr;
   logic               r_busy;
   logic               r_done;

   logic [2:0]         w_nstate;
   logic [CW-1:0]      w_ncnt;
   logic [N*8-1:0]     w_row;
   logic [N*8-1:0]     w_col;

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = '0;
      case (r_state)
         c_ST_IDLE: begin
            if (bus.start) w_nstate = c_ST_CLEAR;
         end
         c_ST_CLEAR: begin
            w_nstate = c_ST_FEED;
         end
         c_ST_FEED: begin
            if (r_cnt == c_FEED_LAST) w_nstate = c_HAS_DRAIN ? c_ST_DRAIN : c_ST_DONE;
            else                      w_ncnt   = r_cnt + CW'(1);
         end
         c_ST_DRAIN: begin
            if (r_cnt == c_DRAIN_LAST) w_nstate = c_ST_DONE;
            else                       w_ncnt   = r_cnt + CW'(1);
         end
         c_ST_DONE: begin
            w_nstate = c_ST_IDLE;
         end
         default: begin
            w_nstate = c_ST_IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so the registered values line up with that state's cycles.
   always_comb begin
      w_row = '0;
      w_col = '0;
      if (w_nstate == c_ST_FEED) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (w_ncnt == CW'(i + k)) begin
                  w_row[i*8 +: 8] = r_a[(i*N + k)*8 +: 8];
                  w_col[i*8 +: 8] = r_b[(k*N + i)*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= c_ST_IDLE;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_process <= 1'b0;
         r_acc_clr <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         if ((r_state == c_ST_IDLE) && bus.start) begin
            r_a <= bus.a_mat;
            r_b <= bus.b_mat;
         end
         r_row     <= w_row;
         r_col     <= w_col;
         r_process <= (w_nstate == c_ST_FEED) || (w_nstate == c_ST_DRAIN);
         r_acc_clr <= (w_nstate == c_ST_CLEAR);
         r_busy    <= (w_nstate != c_ST_IDLE);
         r_done    <= (w_nstate == c_ST_DONE);
      end
   end

   assign bus.ready    = (r_state == c_ST_IDLE);
   assign bus.row_data = r_row;
   assign bus.col_data = r_col;
   assign bus.process  = r_process;
   assign bus.acc_clr  = r_acc_clr;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_systolic_feeder: randomized bench with a cycle-level reference  |
// | model of the skewed streams and an array-product model.  Rev 1.0  |
// +------------------------------------------------------------------+
module tb_systolic_feeder;
   localparam int N      = 4;
   localparam int PE_LAT = 1;
   localparam int L      = 3*N + PE_LAT;
   localparam int W      = 2*N*8 + 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   systolic_feeder_if #(.N(N)) bus ();
   systolic_feeder #(.N(N), .PE_LAT(PE_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [7:0] ma [N][N];
   logic [7:0] mb [N][N];
   logic [7:0] rs [L+2][N];
   logic [7:0] cs [L+2][N];
   int         cres [N][N];

   function automatic logic [N*N*8-1:0] pack_m(input bit sel_b);
      logic [N*N*8-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[(r*N + c)*8 +: 8] = sel_b ? mb[r][c] : ma[r][c];
      return v;
   endfunction

   function automatic logic [N*N*8-1:0] rnd_flat();
      logic [N*N*8-1:0] v;
      for (int i = 0; i < N*N; i++) v[i*8 +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic fill_rand();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 8'($urandom);
            mb[r][c] = 8'($urandom);
         end
   endtask

   function automatic logic [W-1:0] obs();
      return {bus.row_data, bus.col_data, bus.process, bus.acc_clr, bus.busy, bus.done, bus.ready};
   endfunction

   // Expected outputs in cycle c after a handshake at edge 0.
   function automatic logic [W-1:0] exp_vec(input int c);
      logic [N*8-1:0] r, co;
      logic pr, clr, bs, dn, rd;
      int f;
      r = '0; co = '0; pr = 0; clr = 0; bs = 0; dn = 0; rd = 0;
      if (c == 1) begin
         clr = 1; bs = 1;
      end else if (c >= 2 && c <= 2*N) begin
         f = c - 2; pr = 1; bs = 1;
         for (int i = 0; i < N; i++)
            if (f - i >= 0 && f - i < N) begin
               r[i*8 +: 8]  = ma[i][f-i];
               co[i*8 +: 8] = mb[f-i][i];
            end
      end else if (c > 2*N && c < L) begin
         pr = 1; bs = 1;
      end else if (c == L) begin
         dn = 1; bs = 1;
      end else begin
         rd = 1;
      end
      return {r, co, pr, clr, bs, dn, rd};
   endfunction

   // Ideal array: PE(i,j) sees row i delayed by j and column j delayed by i.
   task automatic check_product(input string name);
      int want, got;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            want = 0; got = 0;
            for (int k = 0; k < N; k++)
               want += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
            for (int t = 1; t <= L + 1 + N; t++)
               if (t - j >= 1 && t - j <= L + 1 && t - i >= 1 && t - i <= L + 1)
                  got += int'($signed(rs[t-j][i])) * int'($signed(cs[t-i][j]));
            cres[i][j] = got;
            tests++;
            if (got !== want) begin
               fails++;
               $display("FAIL %s product C[%0d][%0d]: got %0d want %0d", name, i, j, got, want);
            end
         end
   endtask

   // Entered at a negedge with the feeder idle (or start already held).
   task automatic run_op(input string name, input bit hold, input bit scramble);
      logic [W-1:0] got, want;
      bus.a_mat = pack_m(0);
      bus.b_mat = pack_m(1);
      bus.start = 1'b1;
      for (int c = 1; c <= L + 1; c++) begin
         @(posedge clk); @(negedge clk);
         got  = obs();
         want = exp_vec(c);
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h want %h", name, c, got, want);
         end
         for (int i = 0; i < N; i++) begin
            rs[c][i] = bus.row_data[i*8 +: 8];
            cs[c][i] = bus.col_data[i*8 +: 8];
         end
         bus.start = hold;
         if (scramble) begin
            bus.a_mat = rnd_flat();
            bus.b_mat = rnd_flat();
         end
      end
      check_product(name);
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if (obs() !== W'(1)) begin
         fails++;
         $display("FAIL reset_values: got %h want %h", obs(), W'(1));
      end
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);
      tests++;
      if (obs() !== W'(1)) begin
         fails++;
         $display("FAIL reset_start_ignored: got %h want %h", obs(), W'(1));
      end
      bus.start = 1'b0;
   endtask

   task automatic test_skew();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 8'(r*N + c + 1);
            mb[r][c] = 8'(8'h40 + r*N + c);
         end
      run_op("skew", 0, 0);
   endtask

   task automatic test_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = (r == c) ? 8'd1 : 8'd0;
            mb[r][c] = 8'(4*r + c + 1);
         end
      run_op("identity", 0, 1);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            tests++;
            if (cres[i][j] !== 4*i + j + 1) begin
               fails++;
               $display("FAIL identity_equals_b C[%0d][%0d]: got %0d want %0d", i, j, cres[i][j], 4*i + j + 1);
            end
         end
   endtask

   task automatic test_signed_extremes();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 8'h80;
            mb[r][c] = 8'h7F;
         end
      run_op("extremes", 0, 0);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            tests++;
            if (cres[i][j] !== -65024) begin
               fails++;
               $display("FAIL extremes_value C[%0d][%0d]: got %0d want -65024", i, j, cres[i][j]);
            end
         end
   endtask

   task automatic test_back_to_back();
      fill_rand();
      run_op("b2b_first", 1, 1);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) ma[r][c] = 8'h00;
      run_op("b2b_second", 0, 1);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            tests++;
            if (cres[i][j] !== 0) begin
               fails++;
               $display("FAIL b2b_zero C[%0d][%0d]: got %0d want 0", i, j, cres[i][j]);
            end
         end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         fill_rand();
         run_op("random", 0, (n % 2) == 1);
      end
   endtask

   task automatic test_reset_midfeed();
      fill_rand();
      bus.a_mat = pack_m(0);
      bus.b_mat = pack_m(1);
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst = 1'b0;
      #1;
      tests++;
      if (obs() !== W'(1)) begin
         fails++;
         $display("FAIL midfeed_reset_immediate: got %h want %h", obs(), W'(1));
      end
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      tests++;
      if (obs() !== W'(1)) begin
         fails++;
         $display("FAIL midfeed_reset_release: got %h want %h", obs(), W'(1));
      end
      fill_rand();
      run_op("after_reset", 0, 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a_mat = '0;
      bus.b_mat = '0;
      rst       = 1'b0;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_skew();
      test_identity();
      test_signed_extremes();
      test_back_to_back();
      test_random();
      test_reset_midfeed();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
